imem_dmem_arbiter: RTL and testbench
====================================

// Module: imem_dmem_arbiter
// PURPOSE
//  Shares one byte-lane memory bank (4 x memory_array, 8-bit lanes, registered read) between the instruction-fetch
//  port and the load/store port of the core. Arbitrates with data priority plus IF starvation guard; generates per-lane
//  write enables and replicated store data for SB/SH/SW; aligns and sign/zero-extends LB/LH/LW/LBU/LHU read data.
//  Sits between the core and the memory arrays; owns the 4 KiB window at address[31:12] == BASE_PAGE.
// PARAMETERS
//  MEM_ADDR_WIDTH  10      word-index width driven to arrays (mem_address = addr[MEM_ADDR_WIDTH+1:2])
//  BASE_PAGE       20'd1   value of addr[31:12] that selects this memory; other addresses are out-of-window
//  STARVE_LIMIT    4       consecutive cycles of denied if_req after which IF wins arbitration (range 1..15)
// PORTS
//  clk           in   1    clock, all state on rising edge
//  rst           in   1    asynchronous reset, active-high
//  if_req        in   1    fetch request; held with if_addr stable until if_gnt
//  if_addr       in   32   fetch byte address; [1:0] ignored
//  if_gnt        out  1    fetch accepted this cycle (combinational)
//  if_rvalid     out  1    fetch data valid (registered)
//  if_rdata      out  32   fetched word
//  d_req         in   1    load/store request; held with d_we/d_funct3/d_addr/d_wdata stable until d_gnt
//  d_we          in   1    1 = store, 0 = load
//  d_funct3      in   3    RV32I width code
//  d_addr        in   32   byte address
//  d_wdata       in   32   store data, right-aligned
//  d_gnt         out  1    data request accepted this cycle (combinational)
//  d_rvalid      out  1    load data / store acknowledge valid (registered)
//  d_rdata       out  32   extended load data; 0 for stores
//  d_err         out  1    misaligned or illegal funct3; valid with d_rvalid
//  mem_address   out  MEM_ADDR_WIDTH  word index to all four lanes
//  mem_we        out  4    per-lane write enable, lane i = byte i (little-endian)
//  mem_wdata     out  32   lane i data = mem_wdata[8i+7:8i]
//  mem_rdata     in   32   lane read data, valid one cycle after mem_address
// BEHAVIOUR
//  - FSM: IDLE, RESP_IF, RESP_D. Grants issue only in IDLE; at most one grant per cycle.
//  - IDLE: d_req & ~(starve_cnt >= STARVE_LIMIT & if_req) -> d_gnt, next RESP_D; else if_req -> if_gnt, next RESP_IF.
//    RESP_*: assert matching rvalid for exactly one cycle, return to IDLE. Throughput one access per 2 cycles.
//  - Latency: gnt in cycle N, rvalid+data in N+1. Request signals may change in N+1.
//  - starve_cnt: +1 (saturating at 15) each cycle if_req=1 & if_gnt=0, incl. RESP cycles; cleared on if_gnt.
//  - Grant cycle drives mem_address from granted address; mem_we nonzero only for an in-window, legal, aligned
//    store granted this cycle (write completes at that edge). In all other cycles mem_we = 0.
//  - Stores: SB(000) we=1<<a[1:0], wdata={4{b}}; SH(001) we=a[1]?1100:0011, wdata={2{h}}; SW(010) we=1111.
//  - Loads: LB(000)/LH(001) sign-extend, LW(010), LBU(100)/LHU(101) zero-extend; lane selected by a[1:0]
//    latched at grant together with funct3, in-window flag and error flag.
//  - d_err: half with a[0]=1, word with a[1:0]!=0, load funct3 in {011,110,111}, store funct3 > 010.
//    On error: no write, d_rdata=0, d_err=1 with d_rvalid.
//  - Out-of-window (addr[31:12] != BASE_PAGE): no write, rdata=0, err=0 (data) -- still acked in N+1. Same for IF.
//  - rdata outputs hold 0 when rvalid=0; d_err=0 when d_rvalid=0.
//  - Reset (async, any state incl. RESP_*): state IDLE, starve_cnt 0, if_rvalid/d_rvalid/d_err 0, rdata 0;
//    gnt and mem_we forced 0 while rst=1; pending response dropped. First grant possible in first cycle after release.
// TESTING
//  1 IF only, if_addr=0x0000_1008, word 2=0x00A00093 -> if_gnt @N, if_rvalid @N+1, if_rdata=0x00A00093.
//  2 if_req & d_req both @N (LW 0x1004) -> d_gnt @N, d_rvalid @N+1, if_gnt @N+2, if_rvalid @N+3.
//  3 d_req held high continuously with if_req -> d_gnt @N,N+2; starve_cnt hits 4; if_gnt @N+4, counter 0.
//  4 SB 0x1003 wdata=0x000000AB -> mem_we=1000, mem_wdata=0xABABABAB; LB 0x1003 -> 0xFFFFFFAB; LBU -> 0x000000AB.
//  5 LW 0x1002 -> d_err=1, d_rdata=0; SH 0x1001 -> mem_we=0, d_err=1; LW 0x0000_2000 -> d_rdata=0, d_err=0.
//  6 rst pulsed in RESP_D -> d_rvalid=0 same cycle, no response after release; next if_req granted 1st cycle.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one 4-lane byte memory bank between instruction fetch and load/store.
// Data has priority unless fetch has been starved; handles store lane enables and load extension.
module imem_dmem_arbiter #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter logic [19:0] BASE_PAGE = 20'd1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [31:0]               if_addr,
  output logic                      if_gnt,
  output logic                      if_rvalid,
  output logic [31:0]               if_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [2:0]                d_funct3,
  input  logic [31:0]               d_addr,
  input  logic [31:0]               d_wdata,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [31:0]               d_rdata,
  output logic                      d_err,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]                mem_we,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata
);

  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  state_t      state, state_next;
  logic [3:0]  starve_cnt;
  logic        starve_hit;
  logic        d_inwin, if_inwin, d_bad;

  // Attributes of the granted data access, consumed in the response cycle.
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic        we_q, ok_q, err_q, if_inwin_q;

  assign d_inwin    = (d_addr[31:12] == BASE_PAGE);
  assign if_inwin   = (if_addr[31:12] == BASE_PAGE);
  assign starve_hit = (starve_cnt >= STARVE_LIM) && if_req;

  always_comb begin
    d_bad = 1'b0;
    if (d_we) begin
      unique case (d_funct3)
        3'b000:  d_bad = 1'b0;
        3'b001:  d_bad = d_addr[0];
        3'b010:  d_bad = (d_addr[1:0] != 2'b00);
        default: d_bad = 1'b1;
      endcase
    end else begin
      unique case (d_funct3)
        3'b000, 3'b100: d_bad = 1'b0;
        3'b001, 3'b101: d_bad = d_addr[0];
        3'b010:         d_bad = (d_addr[1:0] != 2'b00);
        default:        d_bad = 1'b1;
      endcase
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst) begin
          if (d_req && !starve_hit) begin
            d_gnt      = 1'b1;
            state_next = RESP_D;
          end else if (if_req) begin
            if_gnt     = 1'b1;
            state_next = RESP_IF;
          end
        end
      end
      RESP_IF, RESP_D: state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  assign mem_address = d_gnt ? d_addr[MEM_ADDR_WIDTH+1:2] : if_addr[MEM_ADDR_WIDTH+1:2];

  always_comb begin
    mem_we    = 4'b0000;
    mem_wdata = d_wdata;
    unique case (d_funct3)
      3'b000:  mem_wdata = {4{d_wdata[7:0]}};
      3'b001:  mem_wdata = {2{d_wdata[15:0]}};
      default: mem_wdata = d_wdata;
    endcase
    if (d_gnt && d_we && d_inwin && !d_bad) begin
      unique case (d_funct3)
        3'b000:  mem_we = 4'b0001 << d_addr[1:0];
        3'b001:  mem_we = d_addr[1] ? 4'b1100 : 4'b0011;
        default: mem_we = 4'b1111;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      lane_q     <= 2'd0;
      funct3_q   <= 3'd0;
      we_q       <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      if_inwin_q <= 1'b0;
    end else begin
      state <= state_next;
      if (if_gnt)
        starve_cnt <= 4'd0;
      else if (if_req && starve_cnt != 4'd15)
        starve_cnt <= starve_cnt + 4'd1;
      if (d_gnt) begin
        lane_q   <= d_addr[1:0];
        funct3_q <= d_funct3;
        we_q     <= d_we;
        ok_q     <= d_inwin && !d_bad;
        err_q    <= d_inwin && d_bad;
      end
      if (if_gnt)
        if_inwin_q <= if_inwin;
    end
  end

  assign if_rvalid = (state == RESP_IF);
  assign d_rvalid  = (state == RESP_D);
  assign if_rdata  = (if_rvalid && if_inwin_q) ? mem_rdata : 32'd0;
  assign d_err     = d_rvalid && err_q;

  logic [31:0] shifted;
  assign shifted = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    d_rdata = 32'd0;
    if (d_rvalid && !we_q && ok_q) begin
      unique case (funct3_q)
        3'b000:  d_rdata = {{24{shifted[7]}}, shifted[7:0]};
        3'b001:  d_rdata = {{16{shifted[15]}}, shifted[15:0]};
        3'b100:  d_rdata = {24'd0, shifted[7:0]};
        3'b101:  d_rdata = {16'd0, shifted[15:0]};
        default: d_rdata = mem_rdata;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: a vector table of single accesses plus
// hand-written sequences for contention, starvation and reset during a response.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [9:0]  mem_address;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte-lane memory bank with registered read; reset reloads the first four words.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 32'h4433_2211;
      mem[1] <= 32'h1122_3344;
      mem[2] <= 32'h00A0_0093;
      mem[3] <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_address][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= mem[mem_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_if;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    if (v.is_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_funct3 = v.f3; d_addr = v.addr; d_wdata = v.wdata;
    end
    #1;
    check({tag, " gnt"}, {30'd0, if_gnt, d_gnt}, v.is_if ? 32'd2 : 32'd1);
    check({tag, " mem_we"}, {28'd0, mem_we}, {28'd0, v.exp_we});
    if (v.exp_we != 4'b0000) check({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
    @(negedge clk);
    if (v.is_if) begin
      check({tag, " if_rvalid"}, {31'd0, if_rvalid}, 32'd1);
      check({tag, " if_rdata"}, if_rdata, v.exp_rdata);
    end else begin
      check({tag, " d_rvalid"}, {31'd0, d_rvalid}, 32'd1);
      check({tag, " d_rdata"}, d_rdata, v.exp_rdata);
      check({tag, " d_err"}, {31'd0, d_err}, {31'd0, v.exp_err});
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  initial begin
    logic [6:0] exp_dg, exp_ig;

    //            is_if we  f3      addr          wdata         exp_we   exp_wdata     exp_rdata     err
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_1008, 32'h0,        4'b0000, 32'h0,        32'h00A0_0093, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        4'b0000, 32'h0,        32'hFFFF_FFAB, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'b100, 32'h0000_1003, 32'h0,        4'b0000, 32'h0,        32'h0000_00AB, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'b001, 32'h0000_1002, 32'h0,        4'b0000, 32'h0,        32'hFFFF_AB33, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'b101, 32'h0000_1000, 32'h0,        4'b0000, 32'h0,        32'h0000_2211, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_1006, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'b010, 32'h0000_1004, 32'h0,        4'b0000, 32'h0,        32'hBEEF_3344, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_100C, 32'h8000_0001, 4'b1111, 32'h8000_0001, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'b001, 32'h0000_100C, 32'h0,        4'b0000, 32'h0,        32'h0000_0001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'b001, 32'h0000_100E, 32'h0,        4'b0000, 32'h0,        32'hFFFF_8000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'b000, 32'h0000_1001, 32'h0,        4'b0000, 32'h0,        32'h0000_0022, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'b010, 32'h0000_1002, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_1001, 32'h0000_1234, 4'b0000, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 1'b0, 3'b010, 32'h0000_2000, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'b011, 32'h0000_1000, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 1'b0, 3'b110, 32'h0000_1000, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 1'b1, 3'b011, 32'h0000_1000, 32'hFFFF_FFFF, 4'b0000, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_2000, 32'h0000_00FF, 4'b0000, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'b010, 32'h0000_1000, 32'h0,        4'b0000, 32'h0,        32'hAB33_2211, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_2008, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0});

    // Reset state: requests present but nothing granted or written.
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h1008;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h1000; d_wdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check("rst gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
    check("rst mem_we", {28'd0, mem_we}, 32'd0);
    check("rst rvalid/err", {29'd0, if_rvalid, d_rvalid, d_err}, 32'd0);
    check("rst if_rdata", if_rdata, 32'd0);
    check("rst d_rdata", d_rdata, 32'd0);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Simultaneous requests: data first, fetch two cycles later.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h1008;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h1004;
    #1;
    check("both N gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
    @(negedge clk);
    check("both N+1 d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("both N+1 d_rdata", d_rdata, 32'hBEEF_3344);
    check("both N+1 gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
    d_req = 1'b0;
    @(negedge clk); #1;
    check("both N+2 gnt", {30'd0, if_gnt, d_gnt}, 32'd2);
    @(negedge clk);
    check("both N+3 if_rvalid", {31'd0, if_rvalid}, 32'd1);
    check("both N+3 if_rdata", if_rdata, 32'h00A0_0093);
    if_req = 1'b0;

    // Starvation guard: both held; fetch wins on the third grant slot, counter then clears.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h1008;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h1004;
    exp_dg = 7'b1000101;
    exp_ig = 7'b0010000;
    for (int k = 0; k < 7; k++) begin
      #1;
      check($sformatf("starve c%0d d_gnt", k), {31'd0, d_gnt}, {31'd0, exp_dg[k]});
      check($sformatf("starve c%0d if_gnt", k), {31'd0, if_gnt}, {31'd0, exp_ig[k]});
      @(negedge clk);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Reset asserted during a data response drops it; fetch granted right after release.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h1000;
    #1;
    check("rstresp gnt", {31'd0, d_gnt}, 32'd1);
    @(posedge clk); #1;
    check("rstresp d_rvalid pre", {31'd0, d_rvalid}, 32'd1);
    d_we = 1'b1;
    rst = 1'b1;
    #1;
    check("rstresp d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("rstresp d_rdata", d_rdata, 32'd0);
    check("rstresp gnt/we", {26'd0, mem_we, if_gnt, d_gnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_req = 1'b1; if_addr = 32'h1008;
    #1;
    check("rstresp release d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("rstresp release if_gnt", {31'd0, if_gnt}, 32'd1);
    @(negedge clk);
    check("rstresp if_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd2);
    check("rstresp if_rdata", if_rdata, 32'h00A0_0093);
    if_req = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
